// File: rtl/pattern_sequencer.sv
// pattern_sequencer: frame-synchronous pattern/ramp-step controller; PATTERN_SEQ_AUTO_STEP_EN builds the ramp-step divider
module pattern_sequencer #(
  parameter int B               = 8,
  parameter int X_BITS          = 13,
  parameter int FRACTIONAL_BITS = 12,
  parameter int NUM_PATTERNS    = 5,
  parameter int DWELL_W         = 8
) (
  input  logic                         clk_in,
  input  logic                         reset,
  input  logic                         vn_in,
  input  logic [X_BITS-1:0]            total_active_pix,
  input  logic [DWELL_W-1:0]           dwell_frames,
  input  logic                         auto_en,
  input  logic                         sel_valid,
  input  logic [7:0]                   sel_pattern,
  output logic                         sel_ready,
  input  logic [B+FRACTIONAL_BITS-1:0] ramp_step_cfg,
  output logic [7:0]                   pattern,
  output logic [B+FRACTIONAL_BITS-1:0] ramp_step,
  output logic                         step_valid,
  output logic                         frame_strobe
);
  localparam int N = B + FRACTIONAL_BITS;
  localparam logic [7:0] LAST = 8'(NUM_PATTERNS - 1);
  localparam logic [DWELL_W:0] ONE = (DWELL_W+1)'(1);
  logic vn_d_q, pending_q, pending_d, strobe_q, strobe_d;
  logic [7:0] pattern_q, pattern_d, pend_pat_q, pend_pat_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic frame_start, xfer, dwell_hit, advance;
  logic [DWELL_W:0] dwell_eff;
  logic [N-1:0] ramp_q;
  logic valid_q;

  assign frame_start = vn_in & ~vn_d_q;
  assign sel_ready   = ~pending_q;
  assign xfer        = sel_valid & ~pending_q;
  assign dwell_eff   = dwell_frames == '0 ? ONE : {1'b0, dwell_frames};
  assign dwell_hit   = {1'b0, cnt_q} + ONE >= dwell_eff;
  assign advance     = auto_en & dwell_hit;

  // Next-state of the pattern sequencer; a pending request outranks auto-advance at frame start
  always_comb begin
    pending_d  = frame_start & pending_q ? 1'b0 : pending_q | xfer;
    pend_pat_d = xfer ? sel_pattern : pend_pat_q;
    pattern_d  = !frame_start ? pattern_q :
                 pending_q    ? pend_pat_q :
                 advance      ? (pattern_q >= LAST ? 8'd0 : pattern_q + 8'd1) : pattern_q;
    cnt_d      = !frame_start           ? cnt_q :
                 pending_q || advance   ? '0 :
                 cnt_q == '1            ? cnt_q : cnt_q + DWELL_W'(1);
    strobe_d   = pattern_d != pattern_q;
  end

  // Sequencer state registers
  always_ff @(posedge clk_in) begin
    if (reset) begin
      vn_d_q     <= 1'b0;
      pending_q  <= 1'b0;
      pend_pat_q <= '0;
      pattern_q  <= '0;
      cnt_q      <= '0;
      strobe_q   <= 1'b0;
    end else begin
      vn_d_q     <= vn_in;
      pending_q  <= pending_d;
      pend_pat_q <= pend_pat_d;
      pattern_q  <= pattern_d;
      cnt_q      <= cnt_d;
      strobe_q   <= strobe_d;
    end
  end

`ifdef PATTERN_SEQ_AUTO_STEP_EN
  localparam int IW = $clog2(N);
  typedef enum logic [1:0] {IDLE, DIV, DONE} div_state_e;
  div_state_e state_q;
  logic start_q, restart, ge, unused_cfg;
  logic [X_BITS-1:0] op_q, rem_q, rem_d;
  logic [X_BITS:0] shifted;
  logic [N-1:0] quo_q;
  logic [IW-1:0] iter_q;

  assign unused_cfg = ^ramp_step_cfg;
  assign restart    = total_active_pix != op_q;
  assign shifted    = {rem_q, 1'b0};
  assign ge         = shifted >= {1'b0, op_q};
  assign rem_d      = X_BITS'(ge ? shifted - {1'b0, op_q} : shifted);

  // Restoring divider for 2^N / total_active_pix; the leading dividend bit is folded into the start
  // (remainder 1, quotient bit 0), so the DIV state walks the remaining N zero bits
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q <= IDLE;
      start_q <= 1'b1;
      op_q    <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      iter_q  <= '0;
      ramp_q  <= '0;
      valid_q <= 1'b0;
    end else if (start_q || restart) begin
      state_q <= DIV;
      start_q <= 1'b0;
      op_q    <= total_active_pix;
      rem_q   <= X_BITS'(1);
      quo_q   <= '0;
      iter_q  <= '0;
      valid_q <= 1'b0;
    end else if (state_q == DIV) begin
      rem_q  <= rem_d;
      quo_q  <= {quo_q[N-2:0], ge};
      iter_q <= iter_q + IW'(1);
      if (iter_q == IW'(N-1)) state_q <= DONE;
    end else if (state_q == DONE && frame_start) begin
      ramp_q  <= (op_q <= X_BITS'(1)) ? '1 : quo_q;
      valid_q <= 1'b1;
      state_q <= IDLE;
    end
  end
`else
  logic [N-1:0] ramp_d;
  logic valid_d, unused_tap;

  assign unused_tap = ^total_active_pix;

  // Fixed ramp step reloaded at every frame start
  always_comb begin
    ramp_d  = frame_start ? ramp_step_cfg : ramp_q;
    valid_d = valid_q | frame_start;
  end

  // Ramp step registers
  always_ff @(posedge clk_in) begin
    if (reset) begin
      ramp_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      ramp_q  <= ramp_d;
      valid_q <= valid_d;
    end
  end
`endif

  assign pattern      = pattern_q;
  assign frame_strobe = strobe_q;
  assign ramp_step    = ramp_q;
  assign step_valid   = valid_q;
endmodule

// File: tb/tb_pattern_sequencer.sv
// tb_pattern_sequencer: directed table-driven bench for pattern_sequencer
module tb_pattern_sequencer;
  logic clk_in = 1'b0;
  logic reset, vn_in, auto_en, sel_valid, sel_ready, step_valid, frame_strobe;
  logic [12:0] total_active_pix;
  logic [7:0] dwell_frames, sel_pattern, pattern;
  logic [19:0] ramp_step_cfg, ramp_step;
  int total = 0;
  int bad = 0;
  int strobes = 0;
  int pat, strb, strb_after;

  typedef struct {
    int auto_en;
    int dwell;
    int sel;
    int sel_pat;
    int exp_pat;
    int exp_strobe;
  } vec_t;
  vec_t v[22];

  always #5 clk_in = ~clk_in;

  pattern_sequencer dut (
    .clk_in(clk_in), .reset(reset), .vn_in(vn_in), .total_active_pix(total_active_pix),
    .dwell_frames(dwell_frames), .auto_en(auto_en), .sel_valid(sel_valid),
    .sel_pattern(sel_pattern), .sel_ready(sel_ready), .ramp_step_cfg(ramp_step_cfg),
    .pattern(pattern), .ramp_step(ramp_step), .step_valid(step_valid), .frame_strobe(frame_strobe)
  );

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
  endtask

  task automatic frame_sample(output int p, output int s, output int s_after);
    vn_in = 1'b1;
    tick(1);
    p = int'(pattern);
    s = int'(frame_strobe);
    vn_in = 1'b0;
    tick(1);
    s_after = int'(frame_strobe);
    tick(2);
  endtask

  function automatic vec_t mk(int a, int d, int s, int sp, int ep, int es);
    vec_t r;
    r.auto_en = a; r.dwell = d; r.sel = s; r.sel_pat = sp; r.exp_pat = ep; r.exp_strobe = es;
    return r;
  endfunction

  initial begin
    v[0]  = mk(1, 2, 0, 0,    0,    0);
    v[1]  = mk(1, 2, 0, 0,    1,    1);
    v[2]  = mk(1, 2, 0, 0,    1,    0);
    v[3]  = mk(1, 2, 0, 0,    2,    1);
    v[4]  = mk(1, 2, 0, 0,    2,    0);
    v[5]  = mk(1, 2, 0, 0,    3,    1);
    v[6]  = mk(1, 2, 0, 0,    3,    0);
    v[7]  = mk(1, 2, 0, 0,    4,    1);
    v[8]  = mk(1, 2, 0, 0,    4,    0);
    v[9]  = mk(1, 2, 0, 0,    0,    1);
    v[10] = mk(1, 2, 0, 0,    0,    0);
    v[11] = mk(1, 2, 1, 'hFF, 'hFF, 1);
    v[12] = mk(1, 2, 0, 0,    'hFF, 0);
    v[13] = mk(1, 2, 0, 0,    0,    1);
    v[14] = mk(1, 0, 0, 0,    1,    1);
    v[15] = mk(1, 0, 0, 0,    2,    1);
    v[16] = mk(0, 0, 0, 0,    2,    0);
    v[17] = mk(0, 0, 1, 2,    2,    0);
    v[18] = mk(0, 0, 1, 3,    3,    1);
    v[19] = mk(1, 1, 1, 3,    3,    0);
    v[20] = mk(1, 1, 0, 0,    4,    1);
    v[21] = mk(1, 1, 0, 0,    0,    1);

    vn_in = 1'b0; auto_en = 1'b0; sel_valid = 1'b0; sel_pattern = '0; dwell_frames = 8'd1;
    total_active_pix = 13'd1920; ramp_step_cfg = 20'd1638;
    reset = 1'b1;
    tick(3);
    check("rst_pattern", int'(pattern), 0);
    check("rst_ramp", int'(ramp_step), 0);
    check("rst_valid", int'(step_valid), 0);
    check("rst_strobe", int'(frame_strobe), 0);
    check("rst_ready", int'(sel_ready), 1);
    reset = 1'b0;

`ifdef PATTERN_SEQ_AUTO_STEP_EN
    frame_sample(pat, strb, strb_after);
    check("div_early_ramp", int'(ramp_step), 0);
    check("div_early_valid", int'(step_valid), 0);
    tick(5);
    total_active_pix = 13'd1280;
    tick(10);
    frame_sample(pat, strb, strb_after);
    check("restart_ramp", int'(ramp_step), 0);
    check("restart_valid", int'(step_valid), 0);
    tick(30);
    frame_sample(pat, strb, strb_after);
    check("ramp_1280", int'(ramp_step), 819);
    check("valid_1280", int'(step_valid), 1);
    check("div_pattern", pat, 0);
    total_active_pix = 13'd1920;
    tick(3);
    check("valid_drop", int'(step_valid), 0);
    check("ramp_hold", int'(ramp_step), 819);
    tick(30);
    frame_sample(pat, strb, strb_after);
    check("ramp_1920", int'(ramp_step), 546);
    check("valid_1920", int'(step_valid), 1);
    total_active_pix = 13'd0;
    tick(30);
    frame_sample(pat, strb, strb_after);
    check("ramp_div0", int'(ramp_step), 'hFFFFF);
    total_active_pix = 13'd640;
    tick(20);
    vn_in = 1'b1;
    tick(1);
    vn_in = 1'b0;
    check("done_collide_ramp", int'(ramp_step), 'hFFFFF);
    check("done_collide_valid", int'(step_valid), 0);
    tick(3);
    frame_sample(pat, strb, strb_after);
    check("ramp_640", int'(ramp_step), 1638);
    check("valid_640", int'(step_valid), 1);
`else
    frame_sample(pat, strb, strb_after);
    check("cfg_ramp", int'(ramp_step), 1638);
    check("cfg_valid", int'(step_valid), 1);
    check("cfg_pattern", pat, 0);
    ramp_step_cfg = 20'd77;
    tick(3);
    check("cfg_hold", int'(ramp_step), 1638);
    frame_sample(pat, strb, strb_after);
    check("cfg_reload", int'(ramp_step), 77);
`endif

    do_reset();
    for (int i = 0; i < 22; i++) begin
      auto_en = v[i].auto_en[0];
      dwell_frames = 8'(v[i].dwell);
      if (v[i].sel != 0) begin
        sel_valid = 1'b1;
        sel_pattern = 8'(v[i].sel_pat);
        tick(1);
        sel_valid = 1'b0;
        check($sformatf("row%0d_ready_low", i), int'(sel_ready), 0);
        check($sformatf("row%0d_pattern_early", i), int'(pattern), i == 0 ? 0 : v[i-1].exp_pat);
      end
      tick(1);
      frame_sample(pat, strb, strb_after);
      check($sformatf("row%0d_pattern", i), pat, v[i].exp_pat);
      check($sformatf("row%0d_strobe", i), strb, v[i].exp_strobe);
      check($sformatf("row%0d_strobe_end", i), strb_after, 0);
      if (v[i].sel != 0) check($sformatf("row%0d_ready_back", i), int'(sel_ready), 1);
      if (i < 11) strobes += strb;
      if (i == 10) check("auto_strobe_count", strobes, 5);
    end

    auto_en = 1'b0;
    vn_in = 1'b1;
    sel_valid = 1'b1;
    sel_pattern = 8'h07;
    tick(1);
    vn_in = 1'b0;
    sel_valid = 1'b0;
    check("collide_pattern", int'(pattern), 0);
    check("collide_ready", int'(sel_ready), 0);
    tick(3);
    frame_sample(pat, strb, strb_after);
    check("collide_applied", pat, 7);
    check("collide_strobe", strb, 1);

    sel_valid = 1'b1;
    sel_pattern = 8'h09;
    tick(1);
    sel_valid = 1'b0;
    check("pre_reset_ready", int'(sel_ready), 0);
    do_reset();
    check("midrst_ready", int'(sel_ready), 1);
    check("midrst_pattern", int'(pattern), 0);
    frame_sample(pat, strb, strb_after);
    check("midrst_no_apply", pat, 0);
    check("midrst_no_strobe", strb, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
